// File: rtl/ex_pkg.sv
// Shared execute-stage definitions: ALU op / funct encodings
// and the multiply/divide sequencer state type.
package ex_pkg;

   localparam logic [2:0] R_TYPE = 3'b000;

   localparam logic [5:0] F_ADD   = 6'b000000;
   localparam logic [5:0] F_SUB   = 6'b000001;
   localparam logic [5:0] F_AND   = 6'b000010;
   localparam logic [5:0] F_OR    = 6'b000011;
   localparam logic [5:0] F_XOR   = 6'b000100;
   localparam logic [5:0] F_SLL   = 6'b000101;
   localparam logic [5:0] F_SRL   = 6'b000110;
   localparam logic [5:0] F_MULTU = 6'b001000;
   localparam logic [5:0] F_DIVU  = 6'b001001;
   localparam logic [5:0] F_MFHI  = 6'b001010;
   localparam logic [5:0] F_MFLO  = 6'b001011;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_MUL,
      MD_DIV,
      MD_DONE
   } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared mul/div datapath: shift-add for
// multiply (mode=0), restoring shift-subtract for divide (mode=1).
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             mode,
   input  logic [WIDTH:0]   up,
   input  logic [WIDTH-1:0] dn,
   input  logic [WIDTH-1:0] opnd,
   output logic [WIDTH:0]   up_n,
   output logic [WIDTH-1:0] dn_n
);

   logic [WIDTH-1:0] addend;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_s;
   logic [WIDTH:0]   dif;
   logic             ge;

   // up holds acc/remainder, dn holds multiplier/quotient
   always_comb begin
      addend = dn[0] ? opnd : '0;
      sum    = {1'b0, up[WIDTH-1:0]} + {1'b0, addend};
      rem_s  = {up[WIDTH-1:0], dn[WIDTH-1]};
      dif    = rem_s - {1'b0, opnd};
      ge     = rem_s >= {1'b0, opnd};
      up_n   = {1'b0, sum[WIDTH:1]};
      dn_n   = {sum[0], dn[WIDTH-1:1]};
      if (mode) begin
         up_n = ge ? dif : rem_s;
         dn_n = {dn[WIDTH-2:0], ge};
      end
   end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Multi-cycle MULTU/DIVU sequencer with HI/LO and MFHI/MFLO
// reads, stalling the pipeline while an issue cannot be taken.
module ex_muldiv_ctrl
   import ex_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [2:0]       alu_op,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             flush,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic             result_valid,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH) + 1;

   md_state_e        state;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   up;
   logic [WIDTH-1:0] dn;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH:0]   up_n;
   logic [WIDTH-1:0] dn_n;
   logic             accept;
   logic             last;

   assign issue_ready = (state == MD_IDLE);
   assign stall       = issue_valid & ~issue_ready;
   assign accept      = issue_valid & issue_ready & ~flush
                      & (alu_op == R_TYPE);
   assign last        = (cnt == CW'(WIDTH - 1));

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .mode (state == MD_DIV),
      .up   (up),
      .dn   (dn),
      .opnd (opnd),
      .up_n (up_n),
      .dn_n (dn_n)
   );

   // Sequencer FSM, iteration regs, HI/LO and registered pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= MD_IDLE;
         cnt          <= '0;
         up           <= '0;
         dn           <= '0;
         opnd         <= '0;
         hi           <= '0;
         lo           <= '0;
         result       <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         div_by_zero  <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         done         <= 1'b0;
         div_by_zero  <= 1'b0;
         result_valid <= 1'b0;
         unique case (state)
            MD_IDLE: begin
               if (accept) begin
                  cnt <= '0;
                  unique case (1'b1)
                     (funct == F_MULTU): begin
                        opnd  <= op_a;
                        up    <= '0;
                        dn    <= op_b;
                        busy  <= 1'b1;
                        state <= MD_MUL;
                     end
                     (funct == F_DIVU): begin
                        if (op_b == '0) begin
                           lo          <= '1;
                           hi          <= op_a;
                           done        <= 1'b1;
                           div_by_zero <= 1'b1;
                           state       <= MD_DONE;
                        end else begin
                           opnd  <= op_b;
                           up    <= '0;
                           dn    <= op_a;
                           busy  <= 1'b1;
                           state <= MD_DIV;
                        end
                     end
                     (funct == F_MFHI): begin
                        result       <= hi;
                        result_valid <= 1'b1;
                     end
                     (funct == F_MFLO): begin
                        result       <= lo;
                        result_valid <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            MD_MUL, MD_DIV: begin
               if (flush) begin
                  busy  <= 1'b0;
                  state <= MD_IDLE;
               end else begin
                  up  <= up_n;
                  dn  <= dn_n;
                  cnt <= cnt + CW'(1);
                  if (last) begin
                     hi    <= up_n[WIDTH-1:0];
                     lo    <= dn_n;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= MD_DONE;
                  end
               end
            end
            MD_DONE: state <= MD_IDLE;
            default: state <= MD_IDLE;
         endcase
      end
   end

endmodule
